// File: rtl/avalon_pio_pkg.sv
// Shared register map and edge-select encodings for the Avalon-MM PIO blocks.
package avalon_pio_pkg;

  localparam int BUS_W = 32;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input pin: two-flop synchroniser followed by a saturating-count debouncer.
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pin,
  output logic             raw,
  output logic             debounced,
  output logic [CNT_W-1:0] cnt
);

  logic sync1;
  logic sync2;

  // NOTE: clocked state always uses <=, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  assign raw = sync2;

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign debounced = sync2;
      assign cnt       = '0;
    end else begin : g_filter
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      // Any return to the accepted level restarts qualification from zero.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt       <= '0;
          debounced <= 1'b0;
        end else if (sync2 == debounced) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          debounced <= sync2;
          cnt       <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/debounced_in_pio.sv
// Avalon-MM input PIO: debounced pins, sticky edge capture, maskable level irq.
module debounced_in_pio
  import avalon_pio_pkg::*;
#(
  parameter int         WIDTH           = 4,
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         CNT_W           = 16,
  parameter edge_type_e EDGE_TYPE       = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [BUS_W-1:0] writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [BUS_W-1:0] readdata,
  output logic             irq
);

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] debounced_d;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .pin      (in_port[i]),
      .raw      (raw[i]),
      .debounced(debounced[i]),
      .cnt      (cnt[i])
    );
  end

  assign wr_en        = chipselect && !write_n;
  assign edge_clr     = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
  // Bus bits above WIDTH have no register behind them.
  assign unused_wdata = ^writedata;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_set = ~debounced & debounced_d;
      EDGE_ANY:  edge_set = debounced ^ debounced_d;
      default:   edge_set = debounced & ~debounced_d;
    endcase
  end

  // Set has priority over write-1-to-clear so a coincident edge is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      debounced_d  <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      debounced_d  <= debounced;
      edge_capture <= (edge_capture & ~edge_clr) | edge_set;
      if (wr_en && address == ADDR_MASK) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  // NOTE: readdata gets a default before the case so no path infers a latch.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = debounced;
      ADDR_MASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_capture;
      default:   readdata[WIDTH-1:0] = raw;
    endcase
  end

  assign irq = |(edge_capture & irq_mask);

endmodule
